// File: rtl/scan_pkg.sv
// Shared sizing, index helper and identity table for the programmable bit-plane scan.
package scan_pkg;
  localparam int PLANES  = 8;
  localparam int COLS    = 32;
  localparam int N_MODES = 4;
  localparam int DATA_W  = PLANES * COLS;
  localparam int IDX_W   = $clog2(DATA_W);
  localparam int MODE_W  = $clog2(N_MODES);

  typedef logic [DATA_W-1:0][IDX_W-1:0] tbl_t;

  function automatic logic [IDX_W-1:0] flat_idx(input int p, input int c);
    return IDX_W'(p * COLS + c);
  endfunction

  function automatic tbl_t ident_tbl();
    tbl_t t;
    for (int j = 0; j < DATA_W; j++) t[j] = IDX_W'(j);
    return t;
  endfunction

  localparam tbl_t IDENT_TBL = ident_tbl();
endpackage

// File: rtl/scan_xbar.sv
// Combinational scan crossbar: each output position selects one source bit via its table entry.
module scan_xbar #(
  parameter int DATA_W = 256,
  parameter int IDX_W  = $clog2(DATA_W)
) (
  input  logic [DATA_W-1:0]            word,
  input  logic [DATA_W-1:0][IDX_W-1:0] tbl,
  output logic [DATA_W-1:0]            scanned
);
  localparam logic [IDX_W-1:0] TOP = IDX_W'(DATA_W - 1);

  // Both index spaces count from the MSB, so position j maps to bit TOP-j.
  for (genvar j = 0; j < DATA_W; j++) begin : g_pos
    assign scanned[DATA_W-1-j] = word[TOP - tbl[j]];
  end
endmodule

// File: rtl/scan_prog.sv
// Runtime-programmable multi-mode bit-plane scan with valid/ready and 1-cycle registered output.
module scan_prog
  import scan_pkg::*;
#(
  parameter int PLANES  = scan_pkg::PLANES,
  parameter int COLS    = scan_pkg::COLS,
  parameter int N_MODES = scan_pkg::N_MODES
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  in_valid_i,
  output logic                                  in_ready_o,
  input  logic [$clog2(N_MODES)-1:0]            in_mode_i,
  input  logic [PLANES*COLS-1:0]                bpx_i,
  output logic                                  out_valid_o,
  input  logic                                  out_ready_i,
  output logic [$clog2(N_MODES)-1:0]            out_mode_o,
  output logic [PLANES*COLS-1:0]                scanned_o,
  input  logic                                  cfg_we_i,
  input  logic [$clog2(N_MODES)-1:0]            cfg_mode_i,
  input  logic [$clog2(PLANES*COLS)-1:0]        cfg_idx_i,
  input  logic [$clog2(PLANES*COLS)-1:0]        cfg_val_i
);
  localparam int DW = PLANES * COLS;
  localparam int IW = $clog2(DW);

  logic [N_MODES-1:0][DW-1:0][IW-1:0] tbl;
  logic [DW-1:0]                      xbar_out;
  logic                               accept;

  assign in_ready_o = !out_valid_o || out_ready_i;
  assign accept     = in_valid_i && in_ready_o;

  // The crossbar reads the current table, so a same-edge cfg write only affects later words.
  scan_xbar #(.DATA_W(DW), .IDX_W(IW)) u_xbar (
    .word    (bpx_i),
    .tbl     (tbl[in_mode_i]),
    .scanned (xbar_out)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_o <= 1'b0;
      scanned_o   <= '0;
      out_mode_o  <= '0;
    end else if (accept) begin
      out_valid_o <= 1'b1;
      scanned_o   <= xbar_out;
      out_mode_o  <= in_mode_i;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int m = 0; m < N_MODES; m++)
        for (int j = 0; j < DW; j++)
          tbl[m][j] <= IW'(j);
    end else if (cfg_we_i) begin
      tbl[cfg_mode_i][cfg_idx_i] <= cfg_val_i;
    end
  end
endmodule

// File: tb/tb_scan_prog.sv
// Scoreboard bench for scan_prog: driver pushes expected words on accept, monitor pops on consume.
module tb_scan_prog;
  import scan_pkg::*;

  typedef struct packed {
    logic [MODE_W-1:0] mode;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic              clk = 0;
  logic              rst = 1;
  logic              in_valid = 0, in_ready;
  logic [MODE_W-1:0] in_mode = '0;
  logic [DATA_W-1:0] bpx = '0;
  logic              out_valid, out_ready = 1;
  logic [MODE_W-1:0] out_mode;
  logic [DATA_W-1:0] scanned;
  logic              cfg_we = 0;
  logic [MODE_W-1:0] cfg_mode = '0;
  logic [IDX_W-1:0]  cfg_idx = '0, cfg_val = '0;

  int checks = 0, failures = 0, pops = 0, pushes = 0;
  exp_t sb[$];
  int mtbl[N_MODES][DATA_W];

  scan_prog dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_mode_i(in_mode), .bpx_i(bpx), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_mode_o(out_mode), .scanned_o(scanned), .cfg_we_i(cfg_we), .cfg_mode_i(cfg_mode),
    .cfg_idx_i(cfg_idx), .cfg_val_i(cfg_val)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic logic [DATA_W-1:0] model(input logic [DATA_W-1:0] w, input int m);
    logic [DATA_W-1:0] r;
    for (int j = 0; j < DATA_W; j++) r[DATA_W-1-j] = w[DATA_W-1-mtbl[m][j]];
    return r;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < N_MODES; m++)
      for (int j = 0; j < DATA_W; j++) mtbl[m][j] = j;
  endtask

  // Monitor: compare every consumed word against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_output: got %h required none", scanned);
      end else begin
        exp_t e;
        e = sb.pop_front();
        pops++;
        chk("scan_data", scanned, e.data);
        chk("scan_mode", DATA_W'(out_mode), DATA_W'(e.mode));
      end
    end
  end

  // Inputs change 1 time unit after the rising edge; tasks start and end at that point.
  task automatic cfg_wr(input int m, input int idx, input int val);
    cfg_we = 1; cfg_mode = MODE_W'(m); cfg_idx = IDX_W'(idx); cfg_val = IDX_W'(val);
    @(posedge clk);
    mtbl[m][idx] = val;
    #1 cfg_we = 0;
  endtask

  task automatic send(input logic [DATA_W-1:0] w, input int m, input logic [DATA_W-1:0] exp_data,
                      input bit with_cfg = 0, input int cidx = 0, input int cval = 0);
    bit done = 0;
    in_valid = 1; bpx = w; in_mode = MODE_W'(m);
    if (with_cfg) begin
      cfg_we = 1; cfg_mode = MODE_W'(m); cfg_idx = IDX_W'(cidx); cfg_val = IDX_W'(cval);
    end
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(exp_t'{mode: MODE_W'(m), data: exp_data});
        pushes++;
        done = 1;
      end
      @(posedge clk);
      if (done && with_cfg) mtbl[m][cidx] = cval;
      #1;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL accept_timeout: got in_ready=0 required 1");
    end
    in_valid = 0; cfg_we = 0; bpx = $urandom();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [DATA_W-1:0] one, pat, rev, hold_w, w;
  int m;

  initial begin
    one = 256'h1;
    pat = {4{64'h0123456789ABCDEF}};
    rev = {4{64'hF7B3D591E6A2C480}};
    model_reset();

    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("reset_valid", DATA_W'(out_valid), 0);
    chk("reset_scanned", scanned, 0);
    chk("reset_mode", DATA_W'(out_mode), 0);
    chk("reset_in_ready", DATA_W'(in_ready), 1);

    // Latency: one cycle after accept the word is valid.
    in_valid = 1; bpx = one; in_mode = 0;
    @(posedge clk); sb.push_back(exp_t'{mode: '0, data: one}); pushes++;
    #1 in_valid = 0;
    chk("latency_valid", DATA_W'(out_valid), 1);
    idle(1);

    cfg_wr(1, 0, flat_idx(7, 31));
    send(one, 1, {1'b1, 254'b0, 1'b1});
    send(one, 0, one);

    for (int j = 0; j < DATA_W; j++) cfg_wr(2, j, DATA_W - 1 - j);
    send(pat, 2, rev);

    for (int i = 0; i < 1000; i++) begin
      w = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      m = $urandom_range(N_MODES - 1);
      send(w, m, model(w, m));
    end
    idle(2);

    // Backpressure: first word held, second word stalls for 5 cycles.
    out_ready = 0;
    hold_w = 256'hDEAD_BEEF_0000_1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD;
    send(hold_w, 2, model(hold_w, 2));
    in_valid = 1; bpx = pat; in_mode = 3;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      chk("bp_in_ready", DATA_W'(in_ready), 0);
      chk("bp_stable", scanned, model(hold_w, 2));
      chk("bp_mode", DATA_W'(out_mode), 2);
    end
    @(posedge clk); #1 out_ready = 1;
    send(pat, 3, pat);
    send(pat, 2, rev);
    send(one, 1, {1'b1, 254'b0, 1'b1});
    idle(2);

    // Same-edge write and accept in mode 1: this word sees the old entry.
    send(one, 1, {1'b1, 254'b0, 1'b1}, 1, 1, 255);
    send(one, 1, {2'b11, 253'b0, 1'b1});
    idle(2);

    // Reset with a held word and a pending cfg write.
    out_ready = 0;
    send(one, 1, {2'b11, 253'b0, 1'b1});
    rst = 1; cfg_we = 1; cfg_mode = 1; cfg_idx = 0; cfg_val = 7;
    sb.delete(); pushes--;
    @(posedge clk); #1 rst = 0; cfg_we = 0; out_ready = 1;
    model_reset();
    chk("rst_mid_valid", DATA_W'(out_valid), 0);
    chk("rst_mid_scanned", scanned, 0);
    send(one, 1, one);
    send(pat, 2, pat);
    idle(3);

    chk("sb_drained", DATA_W'(sb.size()), 0);
    chk("pop_count", DATA_W'(pops), DATA_W'(pushes));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
